// File: rtl/fetch_queue.sv
// Instruction fetch front-end: issues word fetches over a req/ack handshake and
// buffers PC-tagged words in a small FIFO whose head feeds the IF/ID register.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instValid,
  output logic [31:0] inst,
  output logic [31:0] instPc,
  output logic [2:0]  qCount
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Bit 0 of the state doubles as the request strobe.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_REQ   = 2'b01;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   saved_pc_q, saved_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [AW-1:0] head_idx;
  logic          head_valid_d;
  logic [31:0]   head_inst_d, head_pc_d;
  logic          push, pop;
  logic [31:0]   redir_pc;

  assign redir_pc = redirectPc & ~32'd3;
  assign push     = (state_q == S_REQ) && imemAck && !redirect;
  assign pop      = instValid && !stall && !redirect;

  assign imemReq  = state_q[0];
  assign imemAddr = fetch_pc_q;
  assign qCount   = 3'(count_q);

  // Fetch control: request only while the held entries plus one outstanding fit.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    saved_pc_d = saved_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc;
        end else if ((count_q + PW'(pop)) < PW'(DEPTH)) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (imemAck) begin
            fetch_pc_d = redir_pc;
          end else begin
            saved_pc_d = redir_pc;
            state_d    = S_DRAIN;
          end
        end else if (imemAck) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if ((count_q + PW'(1) - PW'(pop)) >= PW'(DEPTH)) state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (imemAck) begin
          fetch_pc_d = redirect ? redir_pc : saved_pc_q;
          state_d    = S_REQ;
        end else if (redirect) begin
          saved_pc_d = redir_pc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and the next head; a word pushed into an empty queue becomes the head.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + PW'(push) - PW'(pop);
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    head_idx     = rd_ptr_d[AW-1:0];
    head_valid_d = (count_d != '0);
    head_inst_d  = mem_data[head_idx];
    head_pc_d    = mem_pc[head_idx];
    if (push && (wr_ptr_q[AW-1:0] == head_idx)) begin
      head_inst_d = imemData;
      head_pc_d   = fetch_pc_q;
    end
    if (!head_valid_d) begin
      head_inst_d = 32'd0;
      head_pc_d   = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      saved_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      instValid  <= 1'b0;
      inst       <= 32'd0;
      instPc     <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      saved_pc_q <= saved_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instValid  <= head_valid_d;
      inst       <= head_inst_d;
      instPc     <= head_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr_q[AW-1:0]]   <= fetch_pc_q;
      mem_data[wr_ptr_q[AW-1:0]] <= imemData;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: sequential fetch, stall fill, slow memory,
// redirect with drain, redirect on ack, PC wrap and reset mid-request.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  q_count;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int ack_mode = 0;  // 0: never ack, 1: always ack, 2: ack after 3 wait cycles
  int wait_cnt = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'd96)) dut (
    .clk(clk), .reset(reset),
    .imemReq(imem_req), .imemAddr(imem_addr), .imemAck(imem_ack), .imemData(imem_data),
    .stall(stall), .redirect(redirect), .redirectPc(redirect_pc),
    .instValid(inst_valid), .inst(inst), .instPc(inst_pc), .qCount(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  always_comb imem_data = word_of(imem_addr);
  always_comb begin
    case (ack_mode)
      1:       imem_ack = 1'b1;
      2:       imem_ack = imem_req && (wait_cnt == 3);
      default: imem_ack = 1'b0;
    endcase
  end
  always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  // A push must never land in a full queue.
  always @(negedge clk) begin
    if (!reset && imem_req && imem_ack && !redirect) begin
      chk_cnt++;
      if (q_count < 3'd4) pass_cnt++;
      else $display("FAIL push_when_full: qCount=%0d at ack of %h, required < 4", q_count, imem_addr);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; ack_mode = 0;
    step();
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else pass_cnt++;
    chk_cnt++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else pass_cnt++;
    chk_cnt++; if (q_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", q_count); else pass_cnt++;
    chk_cnt++; if (inst !== 32'd0 || inst_pc !== 32'd0)
      $display("FAIL reset_head: got inst=%h pc=%h want 0/0", inst, inst_pc); else pass_cnt++;
  endtask

  task automatic test_sequential();
    apply_reset();
    ack_mode = 1; reset = 1'b0;
    step();
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd96 || inst_valid !== 1'b0)
      $display("FAIL seq_first_req: got req=%b addr=%h valid=%b want 1/60/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(96 + 4 * i) || inst !== word_of(32'(96 + 4 * i))
          || imem_addr !== 32'(100 + 4 * i) || q_count !== 3'd1)
        $display("FAIL seq_%0d: got valid=%b pc=%h inst=%h addr=%h cnt=%0d want 1/%h/%h/%h/1", i,
                 inst_valid, inst_pc, inst, imem_addr, q_count, 32'(96 + 4 * i),
                 word_of(32'(96 + 4 * i)), 32'(100 + 4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    apply_reset();
    ack_mode = 1; stall = 1'b1; reset = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'd96)
        $display("FAIL stall_hold_%0d: got valid=%b pc=%h want 1/00000060", i, inst_valid, inst_pc);
      else pass_cnt++;
    end
    chk_cnt++; if (q_count !== 3'd4 || imem_req !== 1'b0)
      $display("FAIL stall_full: got cnt=%0d req=%b want 4/0", q_count, imem_req); else pass_cnt++;
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_cnt++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(96 + 4 * i))
        $display("FAIL stall_pop_%0d: got valid=%b pc=%h want 1/%h", i, inst_valid, inst_pc, 32'(96 + 4 * i));
      else pass_cnt++;
    end
  endtask

  task automatic test_slow_memory();
    int got = 0;
    logic [31:0] prev_addr = 32'd0;
    logic        prev_wait = 1'b0;
    apply_reset();
    ack_mode = 2; reset = 1'b0;
    for (int c = 0; c < 150 && got < 20; c++) begin
      step();
      if (prev_wait && imem_req) begin
        chk_cnt++;
        if (imem_addr !== prev_addr) $display("FAIL slow_addr_stable: got %h want %h", imem_addr, prev_addr);
        else pass_cnt++;
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (inst_valid) begin
        chk_cnt++;
        if (inst_pc !== 32'(96 + 4 * got) || inst !== word_of(32'(96 + 4 * got)))
          $display("FAIL slow_order_%0d: got pc=%h inst=%h want %h", got, inst_pc, inst, 32'(96 + 4 * got));
        else pass_cnt++;
        got++;
      end
    end
    chk_cnt++; if (got != 20) $display("FAIL slow_count: got %0d want 20", got); else pass_cnt++;
  endtask

  task automatic test_redirect_drain();
    logic found = 1'b0;
    apply_reset();
    ack_mode = 2; reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (imem_req && !imem_ack && imem_addr == 32'd112) begin found = 1'b1; break; end
    end
    chk_cnt++; if (!found) $display("FAIL drain_reach_112: got found=0 want 1"); else pass_cnt++;
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'd112 || inst_valid !== 1'b0 || q_count !== 3'd0)
      $display("FAIL drain_enter: got req=%b addr=%h valid=%b cnt=%0d want 1/70/0/0",
               imem_req, imem_addr, inst_valid, q_count);
    else pass_cnt++;
    for (int c = 0; c < 10 && imem_addr == 32'd112; c++) step();
    chk_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0)
      $display("FAIL drain_restart: got req=%b addr=%h valid=%b want 1/200/0", imem_req, imem_addr, inst_valid);
    else pass_cnt++;
    for (int c = 0; c < 10 && !inst_valid; c++) step();
    chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== word_of(32'h200))
      $display("FAIL drain_first_inst: got valid=%b pc=%h inst=%h want 1/200/%h",
               inst_valid, inst_pc, inst, word_of(32'h200));
    else pass_cnt++;
  endtask

  task automatic test_redirect_ack_stall();
    apply_reset();
    ack_mode = 1; stall = 1'b1; reset = 1'b0;
    step(); step(); step();
    chk_cnt++; if (q_count !== 3'd2 || inst_pc !== 32'd96 || imem_addr !== 32'd104)
      $display("FAIL ras_setup: got cnt=%0d pc=%h addr=%h want 2/60/68", q_count, inst_pc, imem_addr);
    else pass_cnt++;
    redirect = 1'b1; redirect_pc = 32'h403;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk_cnt++; if (inst_valid !== 1'b0 || q_count !== 3'd0 || inst !== 32'd0 || inst_pc !== 32'd0
                   || imem_req !== 1'b1 || imem_addr !== 32'h400)
      $display("FAIL ras_flush: got valid=%b cnt=%0d inst=%h pc=%h req=%b addr=%h want 0/0/0/0/1/400",
               inst_valid, q_count, inst, inst_pc, imem_req, imem_addr);
    else pass_cnt++;
    step();
    chk_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h400 || inst !== word_of(32'h400))
      $display("FAIL ras_first_inst: got valid=%b pc=%h inst=%h want 1/400/%h",
               inst_valid, inst_pc, inst, word_of(32'h400));
    else pass_cnt++;
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] addrs [4];
    addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC; addrs[2] = 32'h0; addrs[3] = 32'h4;
    apply_reset();
    ack_mode = 1; reset = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk_cnt++; if (imem_req !== 1'b0) $display("FAIL wrap_idle: got req=%b want 0", imem_req); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== addrs[i])
        $display("FAIL wrap_addr_%0d: got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, addrs[i]);
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (inst_valid !== 1'b1 || inst_pc !== addrs[i-1])
          $display("FAIL wrap_pc_%0d: got valid=%b pc=%h want 1/%h", i, inst_valid, inst_pc, addrs[i-1]);
        else pass_cnt++;
      end
    end
    reset = 1'b1;
    step();
    chk_cnt++; if (imem_req !== 1'b0 || q_count !== 3'd0 || inst_valid !== 1'b0)
      $display("FAIL mid_reset: got req=%b cnt=%0d valid=%b want 0/0/0", imem_req, q_count, inst_valid);
    else pass_cnt++;
    ack_mode = 0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    test_reset();
    test_sequential();
    test_stall();
    test_slow_memory();
    test_redirect_drain();
    test_redirect_ack_stall();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
